// File: rtl/dsp_strobe_gen_pkg.sv
// Shared types and helpers for the DSP strobe generator.
// Optional phase offsets are enabled with the DSP_STROBE_PHASE_EN macro.
package dsp_strobe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    LOCKED
  } state_t;

  // Width of the settle counter, large enough for any settle length
  localparam int SETTLE_W = 16;

  // Channel-index width; a single channel still needs one select bit
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsp_strobe_gen_if.sv
// Configuration and strobe bundle for dsp_strobe_gen.
// With DSP_STROBE_PHASE_EN defined, a per-write phase offset is added.
interface dsp_strobe_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  import dsp_strobe_pkg::*;

  localparam int CH_W = chan_w(NUM_CH);

  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_chan;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_commit;
`ifdef DSP_STROBE_PHASE_EN
  logic [DIV_W-1:0]  cfg_phase;
`endif
  logic              cfg_ack;
  logic [NUM_CH-1:0] strobe;
  logic              running;
  logic              locked;

`ifdef DSP_STROBE_PHASE_EN
  modport master (
    output cfg_wr, cfg_chan, cfg_div, cfg_commit, cfg_phase,
    input  cfg_ack, strobe, running, locked
  );
  modport slave (
    input  cfg_wr, cfg_chan, cfg_div, cfg_commit, cfg_phase,
    output cfg_ack, strobe, running, locked
  );
`else
  modport master (
    output cfg_wr, cfg_chan, cfg_div, cfg_commit,
    input  cfg_ack, strobe, running, locked
  );
  modport slave (
    input  cfg_wr, cfg_chan, cfg_div, cfg_commit,
    output cfg_ack, strobe, running, locked
  );
`endif

endinterface

// File: rtl/dsp_strobe_gen_chan.sv
// One strobe channel: staged/active ratio, optional phase, down-counter.
// The phase input is tied to zero by the top when DSP_STROBE_PHASE_EN is undefined.
module dsp_strobe_chan #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             commit,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             strobe
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] staged_div;
  logic [DIV_W-1:0] staged_phase;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_next;
  logic [DIV_W-1:0] phase_next;
  logic [DIV_W-1:0] load_cnt;

  // Same-cycle write bypasses into a commit; phase clamps so the first strobe is never earlier than the next cycle
  always_comb begin
    div_next   = wr_en ? div : staged_div;
    phase_next = wr_en ? phase : staged_phase;
    load_cnt   = '0;
    if (div_next != '0) begin
      if (phase_next >= div_next - ONE) begin
        load_cnt = '0;
      end else begin
        load_cnt = div_next - ONE - phase_next;
      end
    end
  end

  // Staged ratio captures writes; commit swaps it in and realigns the counter
  always_ff @(posedge clock) begin
    if (reset) begin
      staged_div   <= '0;
      staged_phase <= '0;
      active_div   <= '0;
      cnt          <= '0;
    end else begin
      if (wr_en) begin
        staged_div   <= div;
        staged_phase <= phase;
      end
      if (commit) begin
        active_div <= div_next;
        cnt        <= load_cnt;
      end else if (run) begin
        if (active_div == '0) begin
          cnt <= '0;
        end else if (cnt == '0) begin
          cnt <= active_div - ONE;
        end else begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

  assign strobe = run && (active_div != '0) && (cnt == '0);

endmodule

// File: rtl/dsp_strobe_gen.sv
// Programmable clock-enable strobe generator with commit/settle/lock control.
// Define DSP_STROBE_PHASE_EN to enable per-channel phase offsets.
module dsp_strobe_gen
  import dsp_strobe_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8,
  parameter int SETTLE = 16
) (
  input logic             clock,
  input logic             reset,
  dsp_strobe_gen_if.slave bus
);

  localparam int CH_W = chan_w(NUM_CH);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  state_t              state;
  state_t              state_next;
  logic [SETTLE_W-1:0] settle;
  logic [SETTLE_W-1:0] settle_next;
  logic                running_q;
  logic                ack_q;
  logic                wr_ok;
  logic                run;
  logic [DIV_W-1:0]    phase_in;
  logic [NUM_CH-1:0]   strobe_vec;

  assign wr_ok = bus.cfg_wr && ({1'b0, bus.cfg_chan} < (CH_W + 1)'(NUM_CH));
  assign run   = (state != IDLE);

`ifdef DSP_STROBE_PHASE_EN
  assign phase_in = bus.cfg_phase;
`else
  assign phase_in = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    dsp_strobe_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .wr_en  (wr_ok && (bus.cfg_chan == CH_W'(i))),
      .commit (bus.cfg_commit),
      .run    (run),
      .div    (bus.cfg_div),
      .phase  (phase_in),
      .strobe (strobe_vec[i])
    );
  end

  // State, settle counter, sticky running flag and the acknowledge pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      settle    <= '0;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_next;
      settle    <= settle_next;
      running_q <= running_q | bus.cfg_commit;
      ack_q     <= wr_ok | bus.cfg_commit;
    end
  end

  // Commit always restarts settling; otherwise count settle down to lock
  always_comb begin
    state_next  = state;
    settle_next = settle;
    if (bus.cfg_commit) begin
      state_next  = SETTLING;
      settle_next = SETTLE_LOAD;
    end else begin
      case (state)
        SETTLING: begin
          if (settle == '0) begin
            state_next = LOCKED;
          end else begin
            settle_next = settle - SETTLE_W'(1);
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  assign bus.strobe  = strobe_vec;
  assign bus.cfg_ack = ack_q;
  assign bus.running = running_q;
  assign bus.locked  = (state == LOCKED);

endmodule

// File: tb/tb_dsp_strobe_gen.sv
// Testbench for dsp_strobe_gen: cycle-accurate arithmetic model feeding a scoreboard.
// Phase scenarios are compiled in when DSP_STROBE_PHASE_EN is defined.
module tb_dsp_strobe_gen;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int ST  = 16;

  typedef struct packed {
    logic       rst;
    logic       wr;
    logic [1:0] chan;
    logic [7:0] div;
    logic [7:0] ph;
    logic       commit;
  } step_t;

  typedef struct packed {
    logic [NCH-1:0] strobe;
    logic           ack;
    logic           running;
    logic           locked;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  int m_staged[NCH];
  int m_sphase[NCH];
  int m_active[NCH];
  int m_pe[NCH];
  int kc = 0;
  bit committed = 1'b0;

  dsp_strobe_gen_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();

  dsp_strobe_gen #(
    .NUM_CH (NCH),
    .DIV_W  (DW),
    .SETTLE (ST)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running master clock
  always #5 clock = ~clock;

  // Hard stop in case something stalls the sequence
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic step_t st(bit rst, bit wr, int chan, int div, int ph, bit commit);
    step_t s;
    s.rst    = rst;
    s.wr     = wr;
    s.chan   = 2'(chan);
    s.div    = 8'(div);
    s.ph     = 8'(ph);
    s.commit = commit;
    return s;
  endfunction

  function automatic step_t idle();
    return st(0, 0, 0, 0, 0, 0);
  endfunction

  // Drive one cycle of stimulus, push the expected outputs of the following cycle, advance
  task automatic drive(input step_t s);
    exp_t e;
    int   t;
    t = cyc + 1;
    reset          = s.rst;
    bus.cfg_wr     = s.wr;
    bus.cfg_chan   = s.chan;
    bus.cfg_div    = s.div;
    bus.cfg_commit = s.commit;
`ifdef DSP_STROBE_PHASE_EN
    bus.cfg_phase  = s.ph;
`endif
    e = '0;
    if (s.rst) begin
      committed = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_staged[i] = 0;
        m_sphase[i] = 0;
        m_active[i] = 0;
        m_pe[i]     = 0;
      end
    end else begin
      e.ack = (s.wr && int'(s.chan) < NCH) || s.commit;
      if (s.wr && int'(s.chan) < NCH) begin
        m_staged[s.chan] = int'(s.div);
`ifdef DSP_STROBE_PHASE_EN
        m_sphase[s.chan] = int'(s.ph);
`else
        m_sphase[s.chan] = 0;
`endif
      end
      if (s.commit) begin
        for (int i = 0; i < NCH; i++) begin
          m_active[i] = m_staged[i];
          if (m_active[i] == 0) m_pe[i] = 0;
          else m_pe[i] = (m_sphase[i] < m_active[i] - 1) ? m_sphase[i] : m_active[i] - 1;
        end
        kc = cyc;
        committed = 1'b1;
      end
      e.running = committed;
      e.locked  = committed && (t - kc >= ST + 1);
      for (int i = 0; i < NCH; i++) begin
        e.strobe[i] = committed && (m_active[i] != 0) && (((t - kc + m_pe[i]) % m_active[i]) == 0);
      end
    end
    sb.push_back(e);
    @(negedge clock);
    cyc++;
  endtask

  task automatic test_reset();
    step_t q[$];
    for (int i = 0; i < 3; i++) q.push_back(st(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 50; i++) q.push_back(idle());
    foreach (q[n]) begin
      exp_t e;
      drive(q[n]);
      e = sb.pop_front();
      checks++;
      if (bus.strobe !== e.strobe) begin
        errors++;
        $display("[TB] FAIL reset_strobe cyc=%0d got=%b exp=%b", cyc, bus.strobe, e.strobe);
      end
      checks++;
      if ({bus.cfg_ack, bus.running, bus.locked} !== {e.ack, e.running, e.locked}) begin
        errors++;
        $display("[TB] FAIL reset_flags cyc=%0d ack/run/lock got=%b exp=%b", cyc,
                 {bus.cfg_ack, bus.running, bus.locked}, {e.ack, e.running, e.locked});
      end
    end
  endtask

  task automatic test_basic_divide();
    step_t q[$];
    q.push_back(st(0, 1, 0, 4, 0, 0));
    q.push_back(st(0, 1, 1, 1, 0, 0));
    q.push_back(idle());
    q.push_back(st(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 30; i++) q.push_back(idle());
    foreach (q[n]) begin
      exp_t e;
      drive(q[n]);
      e = sb.pop_front();
      checks++;
      if (bus.strobe !== e.strobe) begin
        errors++;
        $display("[TB] FAIL basic_strobe cyc=%0d got=%b exp=%b", cyc, bus.strobe, e.strobe);
      end
      checks++;
      if ({bus.cfg_ack, bus.running, bus.locked} !== {e.ack, e.running, e.locked}) begin
        errors++;
        $display("[TB] FAIL basic_flags cyc=%0d ack/run/lock got=%b exp=%b", cyc,
                 {bus.cfg_ack, bus.running, bus.locked}, {e.ack, e.running, e.locked});
      end
    end
  endtask

  task automatic test_disabled_invalid();
    step_t q[$];
    q.push_back(st(0, 1, 1, 0, 0, 0));
    q.push_back(st(0, 1, 3, 9, 0, 0));
    q.push_back(idle());
    q.push_back(st(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 20; i++) q.push_back(idle());
    foreach (q[n]) begin
      exp_t e;
      drive(q[n]);
      e = sb.pop_front();
      checks++;
      if (bus.strobe !== e.strobe) begin
        errors++;
        $display("[TB] FAIL disabled_strobe cyc=%0d got=%b exp=%b", cyc, bus.strobe, e.strobe);
      end
      checks++;
      if ({bus.cfg_ack, bus.running, bus.locked} !== {e.ack, e.running, e.locked}) begin
        errors++;
        $display("[TB] FAIL disabled_flags cyc=%0d ack/run/lock got=%b exp=%b", cyc,
                 {bus.cfg_ack, bus.running, bus.locked}, {e.ack, e.running, e.locked});
      end
    end
  endtask

  task automatic test_recommit();
    step_t q[$];
    q.push_back(st(0, 1, 0, 5, 0, 0));
    q.push_back(st(0, 1, 1, 2, 0, 0));
    q.push_back(st(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 12; i++) q.push_back(idle());
    q.push_back(st(0, 1, 0, 3, 0, 0));
    for (int i = 0; i < 8; i++) q.push_back(idle());
    q.push_back(st(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 7; i++) q.push_back(idle());
    q.push_back(st(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 30; i++) q.push_back(idle());
    foreach (q[n]) begin
      exp_t e;
      drive(q[n]);
      e = sb.pop_front();
      checks++;
      if (bus.strobe !== e.strobe) begin
        errors++;
        $display("[TB] FAIL recommit_strobe cyc=%0d got=%b exp=%b", cyc, bus.strobe, e.strobe);
      end
      checks++;
      if ({bus.cfg_ack, bus.running, bus.locked} !== {e.ack, e.running, e.locked}) begin
        errors++;
        $display("[TB] FAIL recommit_flags cyc=%0d ack/run/lock got=%b exp=%b", cyc,
                 {bus.cfg_ack, bus.running, bus.locked}, {e.ack, e.running, e.locked});
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t q[$];
    q.push_back(st(0, 1, 0, 7, 0, 1));
    for (int i = 0; i < 20; i++) q.push_back(idle());
    q.push_back(st(0, 1, 2, 3, 0, 1));
    for (int i = 0; i < 4; i++) q.push_back(idle());
    q.push_back(st(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) q.push_back(idle());
    foreach (q[n]) begin
      exp_t e;
      drive(q[n]);
      e = sb.pop_front();
      checks++;
      if (bus.strobe !== e.strobe) begin
        errors++;
        $display("[TB] FAIL simul_strobe cyc=%0d got=%b exp=%b", cyc, bus.strobe, e.strobe);
      end
      checks++;
      if ({bus.cfg_ack, bus.running, bus.locked} !== {e.ack, e.running, e.locked}) begin
        errors++;
        $display("[TB] FAIL simul_flags cyc=%0d ack/run/lock got=%b exp=%b", cyc,
                 {bus.cfg_ack, bus.running, bus.locked}, {e.ack, e.running, e.locked});
      end
    end
  endtask

`ifdef DSP_STROBE_PHASE_EN
  task automatic test_phase();
    step_t q[$];
    q.push_back(st(0, 1, 0, 8, 3, 0));
    q.push_back(st(0, 1, 1, 8, 0, 0));
    q.push_back(st(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 20; i++) q.push_back(idle());
    q.push_back(st(0, 1, 0, 8, 10, 1));
    for (int i = 0; i < 12; i++) q.push_back(idle());
    foreach (q[n]) begin
      exp_t e;
      drive(q[n]);
      e = sb.pop_front();
      checks++;
      if (bus.strobe !== e.strobe) begin
        errors++;
        $display("[TB] FAIL phase_strobe cyc=%0d got=%b exp=%b", cyc, bus.strobe, e.strobe);
      end
      checks++;
      if ({bus.cfg_ack, bus.running, bus.locked} !== {e.ack, e.running, e.locked}) begin
        errors++;
        $display("[TB] FAIL phase_flags cyc=%0d ack/run/lock got=%b exp=%b", cyc,
                 {bus.cfg_ack, bus.running, bus.locked}, {e.ack, e.running, e.locked});
      end
    end
  endtask
`endif

  // Scenario sequence
  initial begin
    bus.cfg_wr     = 1'b0;
    bus.cfg_chan   = '0;
    bus.cfg_div    = '0;
    bus.cfg_commit = 1'b0;
`ifdef DSP_STROBE_PHASE_EN
    bus.cfg_phase  = '0;
`endif
    @(negedge clock);
    test_reset();
    test_basic_divide();
    test_disabled_invalid();
    test_recommit();
    test_simultaneous();
`ifdef DSP_STROBE_PHASE_EN
    test_phase();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsp_strobe_gen.md
Name: dsp_strobe_gen

Overview:
- Parametrised successor to the fixed two-output DSP clock PLL: derives NUM_CH programmable clock-enable strobes from the single master clock instead of extra clock domains.
- Per-channel divide ratios are staged through a simple config port and applied atomically on commit. All channels restart phase-aligned.
- A lock flag tells downstream DSP (decimators, interpolators, serial codecs) when strobes are stable.

Parameters:
- NUM_CH, 2, number of strobe channels.
- DIV_W, 8, divide-ratio width; legal ratio 1..2^DIV_W-1, 0 = channel disabled.
- SETTLE, 16, cycles after commit before locked asserts (1..65535).

Ports:
- clock  in  1  master DSP clock.
- reset  in  1  synchronous, active-high reset.
- cfg_wr  in  1  write staged ratio for cfg_chan.
- cfg_chan  in  clog2(NUM_CH) (min 1)  target channel.
- cfg_div  in  DIV_W  ratio value.
- cfg_commit  in  1  apply all staged ratios and realign.
- cfg_ack  out  1  one-cycle pulse acknowledging an accepted wr or commit.
- strobe  out  NUM_CH  per-channel clock-enable.
- running  out  1  at least one commit since reset.
- locked  out  1  strobes stable after settle.

Behaviour:
- Reset (synchronous, active-high):
  - staged and active ratios all 0; counters 0.
  - state IDLE; strobe, cfg_ack, running and locked all 0.
- Reset mid-operation aborts everything on that edge. There is no partial state.
- States:
  - IDLE: no strobes.
  - SETTLING: strobes run, locked = 0.
  - LOCKED: strobes run, locked = 1.
- Transitions:
  - IDLE -> SETTLING on commit.
  - SETTLING -> LOCKED when the settle counter expires.
  - Any state -> SETTLING on commit; a commit during SETTLING restarts settle.
- Config write:
  - cfg_wr with cfg_chan < NUM_CH updates the staged ratio on that edge and pulses cfg_ack the next cycle.
  - cfg_chan >= NUM_CH: write ignored, no ack.
  - Staged writes never affect running strobes.
- Commit sampled high in cycle k:
  - At the edge ending cycle k, active ratio D[i] <= staged ratio for every channel.
  - A same-cycle cfg_wr is included (write bypasses into commit).
  - cnt[i] <= D[i]-1; settle counter <= SETTLE-1; running <= 1; cfg_ack pulses in cycle k+1.
  - A simultaneous wr and commit produce a single ack pulse.
- Counters:
  - In SETTLING or LOCKED, cnt[i] <= (cnt[i]==0) ? D[i]-1 : cnt[i]-1.
  - strobe[i] = running-state AND D[i]!=0 AND cnt[i]==0. This is decoded from registers only; there is no combinational path from inputs.
- Timing:
  - First strobe[i] occurs in cycle k+D[i]; thereafter exactly every D[i] cycles.
  - D=1: strobe high every cycle from k+1.
  - D=0: strobe held 0.
  - Channels whose ratios share a common multiple strobe coincidently at k+lcm.
- locked:
  - Goes 0 at cycle k+1 and goes 1 at cycle k+SETTLE+1, if no further commit arrives.
  - Strobes never glitch or pause across the SETTLING -> LOCKED transition.
- Counters are DIV_W bits wide; no wrap beyond D-1.

Optional Feature:
- Macro DSP_STROBE_PHASE_EN.
- Defined:
  - Adds input cfg_phase [DIV_W-1:0], staged with each cfg_wr.
  - On commit, cnt[i] <= D[i]-1-min(P[i], D[i]-1).
  - First strobe therefore occurs at k+D[i]-P[i]; P >= D clamps to a first strobe at k+1.
  - Staged P resets to 0.
- Undefined: no cfg_phase port; behaviour identical to P=0 everywhere.

Decomposition:
- Package dsp_strobe_pkg:
  - state enum {IDLE, SETTLING, LOCKED}.
  - Settle-counter width constant (16).
  - Function for clog2 channel-index width, min 1.
- Sub-module dsp_strobe_chan:
  - One instance per channel, generated NUM_CH times.
  - Holds the staged/active ratio, optional phase, down-counter and strobe decode.
  - Inputs: wr_en, commit, run, div, phase.

Test Plan:
- Reset defaults: reset for 3 cycles, then idle 50 cycles -> strobe==0, locked==0, running==0, cfg_ack never pulses.
- Basic divide: write ch0=4, ch1=1, commit at cycle k -> ch0 strobes at k+4, k+8, k+12…; ch1 high every cycle from k+1; locked rises at k+17 (SETTLE=16); one ack per write and one for the commit.
- Disabled and out-of-range channels: write ch1=0, write chan=3 (NUM_CH=2), commit -> ch1 stays 0; the invalid write gets no ack and changes no ratio.
- Atomic re-commit: running ch0=5; stage ch0=3 without commit -> period stays 5; commit mid-period at cycle m -> locked drops at m+1, first new strobe at m+3, period 3, no extra strobe; second commit at m+8 -> locked delayed to m+25.
- Simultaneous events:
  - wr(ch0=7) and commit in the same cycle -> D=7 takes effect immediately; exactly one ack.
  - Synchronous reset asserted in SETTLING -> next cycle strobe, running and locked all 0.
- DSP_STROBE_PHASE_EN:
  - ch0 D=8 P=3, ch1 D=8 P=0, commit at k -> ch0 strobes at k+5, k+13; ch1 at k+8, k+16.
  - P=10 with D=8 -> first strobe at k+1.
